// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU MEM stage and DataMemory.
// CPU stores are queued in a FIFO and retired to memory one at a time over a
// mem_we/mem_ack handshake. Loads are checked against every pending entry,
// including the write in flight, so that read-after-write order is preserved.
//
// Build option: define STORE_BUFFER_FWD_EN to forward the youngest matching
// store to the load (ld_hit/ld_data). Without it, a match raises ld_conflict.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   st_en/st_addr/st_data       CPU store request (addr bits [1:0] ignored)
//   st_stall                    store not accepted this cycle (buffer full)
//   ld_en/ld_addr               CPU load probe (addr bits [1:0] ignored)
//   ld_conflict                 load must stall behind a pending store
//   ld_hit/ld_data              forwarded load data (forwarding build only)
//   mem_we/mem_addr/mem_wdata   registered write request to DataMemory
//   mem_ack                     DataMemory accepted the write
//   empty, count                occupancy, count includes the in-flight head
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_en,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_stall,
  input  logic                     ld_en,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_conflict,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = AW - 2;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   head, tail, head_inc;
  logic [CW-1:0]   count_nxt;
  logic            full, push, pop;
  logic            mem_we_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic            ld_match;
  logic            unused_byte_bits;

  // Byte-offset bits are don't-care for word-aligned traffic.
  assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Stall decision looks only at current occupancy; a same-cycle pop does not help.
  assign full      = (count == CW'(DEPTH));
  assign st_stall  = st_en && full;
  assign push      = st_en && !full;
  assign pop       = (state == ISSUE) && mem_ack;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head_inc  = head + PW'(1);
  assign empty     = (count == '0);

  // Entry storage; needs no reset since validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr[AW-1:2];
      data_q[tail] <= st_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head_inc;
      count <= count_nxt;
    end
  end

  // Issue FSM state and registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  // Next-state and next request; request stays stable until acked.
  always_comb begin
    state_nxt     = state;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt     = ISSUE;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = {addr_q[head], 2'b00};
          mem_wdata_nxt = data_q[head];
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          if (count_nxt != '0) begin
            mem_we_nxt = 1'b1;
            // With one entry left the new head is the store landing this edge.
            if (count == CW'(1)) begin
              mem_addr_nxt  = {st_addr[AW-1:2], 2'b00};
              mem_wdata_nxt = st_data;
            end else begin
              mem_addr_nxt  = {addr_q[head_inc], 2'b00};
              mem_wdata_nxt = data_q[head_inc];
            end
          end else begin
            state_nxt  = IDLE;
            mem_we_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DW-1:0] fwd_data;
`endif

  // Scan oldest to youngest so the last match is the youngest store.
  always_comb begin : match_scan
    logic [PW-1:0] idx;
    idx      = '0;
    ld_match = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr_q[idx] == ld_addr[AW-1:2])) begin
        ld_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = data_q[idx];
`endif
      end
    end
    ld_match = ld_match && ld_en;
  end

`ifdef STORE_BUFFER_FWD_EN
  assign ld_conflict = 1'b0;
  assign ld_hit      = ld_match;
  assign ld_data     = ld_match ? fwd_data : '0;
`else
  assign ld_conflict = ld_match;
  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and a write scoreboard.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_en;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_stall;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic          ld_conflict;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];      // model: pending stores, oldest first, head in flight
  wr_t           sb[$];     // scoreboard: writes memory must still see, in order
  logic [DW-1:0] dmem [int];
  wr_t           mon_w;
  bit            we_exp;
  bit            acc_last;
  int            ack_mode;  // 0: never ack, 1: always ack, 2: random
  int            checks = 0;
  int            errors = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a write is presented iff the buffer held something during
  // the previous cycle and still holds something now.
  task automatic model_update();
    bit  acc, pop, was;
    wr_t w;
    acc = st_en && (q.size() < int'(DEPTH));
    pop = we_exp && mem_ack;
    was = q.size() > 0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      w.a = {st_addr[AW-1:2], 2'b00};
      w.d = st_data;
      q.push_back(w);
      sb.push_back(w);
    end
    we_exp   = was && (q.size() > 0);
    acc_last = acc;
  endtask

  task automatic check_outputs();
    bit            m;
    logic [DW-1:0] fd;
    m  = 1'b0;
    fd = '0;
    if (ld_en)
      foreach (q[i])
        if (q[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
          m  = 1'b1;
          fd = q[i].d;
        end
    chk("st_stall", 64'(st_stall), 64'(st_en && (q.size() == int'(DEPTH))));
    chk("count",    64'(count),    64'(q.size()));
    chk("empty",    64'(empty),    64'(q.size() == 0));
    chk("mem_we",   64'(mem_we),   64'(we_exp));
    if (we_exp) begin
      chk("mem_addr",  64'(mem_addr),  64'(q[0].a));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
    end
`ifdef STORE_BUFFER_FWD_EN
    chk("ld_conflict", 64'(ld_conflict), 64'(0));
    chk("ld_hit",      64'(ld_hit),      64'(m));
    chk("ld_data",     64'(ld_data),     64'(fd));
`else
    chk("ld_conflict", 64'(ld_conflict), 64'(m));
    chk("ld_hit",      64'(ld_hit),      64'(0));
    chk("ld_data",     64'(ld_data),     64'(0));
`endif
  endtask

  // One clock: inputs already driven; check mid-cycle, then advance the model.
  task automatic step();
    if (ack_mode == 2) mem_ack = 1'($urandom_range(0, 1));
    else               mem_ack = (ack_mode == 1);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_en   = 1'b1;
    st_addr = a;
    st_data = d;
    acc_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc_last) break;
    end
    checks++;
    if (!acc_last) begin
      errors++;
      $display("FAIL store_timeout addr=%0h not accepted within 64 cycles", a);
    end
    st_en = 1'b0;
  endtask

  task automatic drain();
    st_en    = 1'b0;
    ack_mode = 1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !we_exp) break;
      step();
    end
    checks++;
    if (q.size() != 0 || we_exp) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    chk("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  // Monitor: every accepted memory write must match the next expected store.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                 mem_addr, mem_wdata);
      end else begin
        mon_w = sb.pop_front();
        chk("wr_addr", 64'(mem_addr),  64'(mon_w.a));
        chk("wr_data", 64'(mem_wdata), 64'(mon_w.d));
      end
      dmem[int'(mem_addr[AW-1:2])] = mem_wdata;
    end
  end

  initial begin
    logic [AW-1:0] pick [4];
    pick[0] = 32'h8; pick[1] = 32'h4; pick[2] = 32'h20; pick[3] = 32'h24;
    reset = 1'b1; st_en = 1'b0; st_addr = '0; st_data = '0;
    ld_en = 1'b0; ld_addr = '0; mem_ack = 1'b0; ack_mode = 1;
    we_exp = 1'b0; acc_last = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_count",  64'(count),  64'(0));
    chk("rst_empty",  64'(empty),  64'(1));
    chk("rst_stall",  64'(st_stall), 64'(0));
    chk("rst_ldc",    64'(ld_conflict), 64'(0));
    chk("rst_ldhit",  64'(ld_hit), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    repeat (2) step();

    // Single store with ack tied high
    ack_mode = 1;
    store(32'hC, 32'd45);
    repeat (3) step();

    // Fill to DEPTH with no ack, stall the fifth, then release ack
    ack_mode = 0;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'h50 + 32'(i));
    st_en = 1'b1; st_addr = 32'h110; st_data = 32'h54;
    step(); step();
    ack_mode = 1;
    store(32'h110, 32'h54);
    drain();

    // Wrap-around with random ack gaps
    ack_mode = 2;
    for (int i = 0; i < 10; i++) store(32'h10 + 32'(4 * i), 32'(i));
    drain();
    for (int w = 4; w < 14; w++)
      chk("dmem_word", 64'(dmem.exists(w) ? dmem[w] : 32'hDEADBEEF), 64'(w - 4));

    // Load conflict / forwarding against two pending stores to 0x8
    ack_mode = 0;
    store(32'h8, 32'd7);
    store(32'h8, 32'd9);
    ld_en = 1'b1; ld_addr = 32'h8;
    repeat (3) step();
    ld_addr = 32'h4;
    repeat (2) step();
    ld_addr = 32'h8;
    drain();
    step();
    ld_en = 1'b0;

    // Randomized mixed traffic
    ack_mode = 2;
    for (int c = 0; c < 300; c++) begin
      st_en   = 1'($urandom_range(0, 1));
      st_addr = pick[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      st_data = $urandom;
      ld_en   = 1'($urandom_range(0, 1));
      ld_addr = pick[$urandom_range(0, 3)];
      step();
    end
    ld_en = 1'b0;
    drain();

    // Reset in the middle of an issued write
    ack_mode = 0;
    store(32'h40, 32'hAB);
    step();
    #2;
    chk("pre_reset_we", 64'(mem_we), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_we",    64'(mem_we), 64'(0));
    chk("async_rst_count", 64'(count),  64'(0));
    chk("async_rst_empty", 64'(empty),  64'(1));
    q.delete(); sb.delete(); we_exp = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    ack_mode = 1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU's MEM stage and DataMemory.
- CPU stores are queued in a FIFO and retire to memory one at a time over a req/ack handshake, so the CPU never waits on memory writes unless the buffer is full.
- Loads compare against pending entries to preserve read-after-write ordering.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, 32, byte address width.
- DW, 32, data width (one word per entry).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_en  in  1  CPU store request this cycle.
- st_addr  in  AW  store byte address; bits [1:0] ignored (word aligned).
- st_data  in  DW  store data.
- st_stall  out  1  store not accepted; CPU must hold the request.
- ld_en  in  1  CPU load this cycle.
- ld_addr  in  AW  load byte address; bits [1:0] ignored.
- ld_conflict  out  1  load must stall (pending store to the same word).
- ld_hit  out  1  forwarded data valid (feature only, else tied 0).
- ld_data  out  DW  forwarded data (feature only, else 0).
- mem_we  out  1  write request to DataMemory.
- mem_addr  out  AW  write address; bits [1:0] = 0.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  DataMemory accepted the write this cycle.
- empty  out  1  no pending entries and no write in flight.
- count  out  $clog2(DEPTH)+1  occupied entries, including the head being written.

Behaviour:
- Reset (async, any time): head=tail=count=0; FSM=IDLE; mem_we=0, mem_addr=0, mem_wdata=0; st_stall=0; ld_conflict=0; ld_hit=0; empty=1. Any in-flight write is abandoned and never re-issued.
- Enqueue: at posedge, st_en && !full writes {word addr, data} at tail; tail wraps modulo DEPTH.
- st_stall = st_en && full, combinational on the current count only. A pop in the same cycle does not free a slot for the stalled store; it is accepted next cycle.
- FSM IDLE: if count>0 at posedge → ISSUE. mem_we, mem_addr and mem_wdata are registered from the head entry.
- FSM ISSUE: mem_we=1; mem_addr/mem_wdata stay stable until mem_ack.
  - mem_ack at posedge pops the head (head wraps).
  - If entries remain (counting a same-cycle enqueue), stay in ISSUE and load the new head next cycle. Otherwise go to IDLE with mem_we=0.
- mem_ack while in IDLE is ignored.
- Latency: a store accepted at edge N into an empty buffer gives mem_we=1 from edge N+1. With a one-cycle ack, back-to-back writes issue every cycle.
- Simultaneous enqueue and pop: count is unchanged.
- FIFO order is strict; there is no coalescing of same-address stores.
- Load check (combinational): match = any valid entry, including the in-flight head, whose word addr equals ld_addr[AW-1:2], qualified by ld_en.
- empty = (count==0).

Optional Feature:
- Macro STORE_BUFFER_FWD_EN.
- Defined:
  - On a match, ld_hit=1 and ld_data = data of the youngest matching entry (closest to tail); ld_conflict=0.
  - On no match, ld_hit=0 and ld_data=0.
- Undefined:
  - ld_conflict = match; ld_hit=0; ld_data=0.
  - The CPU holds the load until the matching entries drain to memory.

Test Plan:
- Reset mid-ISSUE: mem_we=1 with mem_ack held 0, then reset pulse → mem_we=0, count=0, empty=1 asynchronously. No further writes after release.
- Single store 0x0000000C/45, mem_ack tied 1 → mem_we high exactly one cycle with mem_addr=0xC, mem_wdata=45; empty=1 two cycles after acceptance.
- Fill with DEPTH=4: 5 consecutive stores, mem_ack=0 → st_stall=1 on the 5th, count=4. Release mem_ack → the 5th store is accepted one cycle after the first pop. Memory sees addresses in issue order.
- Wrap-around: 10 stores addr 0x10+4i, data i, with random ack gaps → DataMemory words 4..13 hold 0..9, no loss or duplication.
- Load conflict: stores to 0x8 (data 7) then 0x8 (data 9) pending, load 0x8 →
  - without macro: ld_conflict=1 until both retire;
  - with STORE_BUFFER_FWD_EN: ld_hit=1, ld_data=9, ld_conflict=0.
  - A load to 0x4 gives no conflict and no hit in either build.
